// File: rtl/axi_8bit_splitter.sv
// Stream fork: one 2*DATA_W-bit AXI-Stream word in, high byte and low byte out on
// two independent DATA_W-bit AXI-Stream masters, each buffered by a 2-entry FIFO.
module axi_8bit_splitter #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2*DATA_W-1:0]   s_axis_data,
   input  logic                  s_axis_valid,
   output logic                  s_axis_ready,
   output logic [DATA_W-1:0]     m_axis_data1,
   output logic                  m_axis_valid1,
   input  logic                  m_axis_ready1,
   output logic [DATA_W-1:0]     m_axis_data2,
   output logic                  m_axis_valid2,
   input  logic                  m_axis_ready2
);

   // Lane 0 is FIFO1 (high byte), lane 1 is FIFO2 (low byte).
   logic [DATA_W-1:0] mem_r    [2][2];
   logic [1:0]        cnt_r    [2];
   logic [1:0]        wr_ptr_r;
   logic [1:0]        rd_ptr_r;
   logic [DATA_W-1:0] in_byte_s [2];
   logic [1:0]        pop_s;
   logic [1:0]        valid_s;
   logic              push_s;
   logic              ready_s;

   // Handshake decode; ready depends on registered counts only, never on the consumer readies.
   always_comb begin
      in_byte_s[0] = s_axis_data[2*DATA_W-1:DATA_W];
      in_byte_s[1] = s_axis_data[DATA_W-1:0];
      valid_s[0]   = (cnt_r[0] != 2'd0);
      valid_s[1]   = (cnt_r[1] != 2'd0);
      pop_s[0]     = valid_s[0] && m_axis_ready1;
      pop_s[1]     = valid_s[1] && m_axis_ready2;
      ready_s      = (cnt_r[0] < 2'd2) && (cnt_r[1] < 2'd2) && rst_n;
      push_s       = s_axis_valid && ready_s;
   end

   // FIFO storage, pointers and occupancy for both lanes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= 2'b00;
         rd_ptr_r <= 2'b00;
         for (int l = 0; l < 2; l++) begin
            cnt_r[l]    <= 2'd0;
            mem_r[l][0] <= {DATA_W{1'b0}};
            mem_r[l][1] <= {DATA_W{1'b0}};
         end
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (push_s) begin
               mem_r[l][wr_ptr_r[l]] <= in_byte_s[l];
               wr_ptr_r[l]           <= ~wr_ptr_r[l];
            end
            if (pop_s[l]) begin
               rd_ptr_r[l] <= ~rd_ptr_r[l];
            end
            case ({push_s, pop_s[l]})
               2'b10:   cnt_r[l] <= cnt_r[l] + 2'd1;
               2'b01:   cnt_r[l] <= cnt_r[l] - 2'd1;
               default: cnt_r[l] <= cnt_r[l];
            endcase
         end
      end
   end

   assign s_axis_ready  = ready_s;
   assign m_axis_valid1 = valid_s[0];
   assign m_axis_valid2 = valid_s[1];
   assign m_axis_data1  = mem_r[0][rd_ptr_r[0]];
   assign m_axis_data2  = mem_r[1][rd_ptr_r[1]];

endmodule
